core_encode: RTL
================

# core_encode

Instruction encoder and program writer: accepts decoded instruction fields (format, opcode, func3, func7, register numbers, immediate) over a valid/ready handshake. Packs them into 32-bit RV32-style instruction words bit-exactly inverse to the core's decode stage. Writes each legal word to consecutive instruction-memory addresses. Used by the boot/self-test path to build programs on chip; illegal or out-of-range fields are rejected and flagged, never written.

## Interface
- ADDR_W, 12, instruction-memory word-address width
- DEPTH, 4096, max words written before FULL; 1 ≤ DEPTH ≤ 2^ADDR_W
- BASE_ADDR, 0, word address of first write after reset/CLEAR
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- CLEAR  in  1  restart program: pointer, COUNT, FULL, ERR cleared
- IN_VALID  in  1  field bundle valid
- IN_READY  out  1  encoder can accept
- FMT  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal
- OPCODE  in  7  INST[6:0]
- FUNC3  in  3  INST[14:12] (R/I/S/B)
- FUNC7  in  7  INST[31:25] (R only)
- RD, RS1, RS2  in  5 each  register numbers (int or FP, same slots)
- IMM  in  32  byte-offset/immediate, two's complement, unshifted
- WE  out  1  instruction-memory write strobe
- WADDR  out  ADDR_W  write word address
- WDATA  out  32  encoded instruction
- COUNT  out  ADDR_W+1  words written since reset/CLEAR
- FULL  out  1  COUNT == DEPTH
- ERR  out  1  sticky: an illegal bundle was rejected
- ERR_ADDR  out  ADDR_W  WADDR that the first rejected bundle would have used

## Operation
- Accept = IN_VALID && IN_READY at rising edge. IN_READY = !FULL && !CLEAR (combinational).
- Packing (FUNC3/FUNC7/unused fields ignored where the format has no slot):
  - R: {FUNC7, RS2, RS1, FUNC3, RD, OPCODE}
  - I: {IMM[11:0], RS1, FUNC3, RD, OPCODE}
  - S: {IMM[11:5], RS2, RS1, FUNC3, IMM[4:0], OPCODE}
  - B: {IMM[12], IMM[10:5], RS2, RS1, FUNC3, IMM[4:1], IMM[11], OPCODE}
  - U: {IMM[31:12], RD, OPCODE}
  - J: {IMM[20], IMM[10:1], IMM[11], IMM[19:12], RD, OPCODE}
- Legality, else reject:
  - I/S: IMM in [-2048, 2047] (IMM[31:11] all equal).
  - B: IMM in [-4096, 4094], IMM[0]=0.
  - J: IMM in [-2^20, 2^20-2], IMM[0]=0.
  - U: IMM[11:0]=0.
  - R: always legal. FMT 6/7: reject.
- Legal accept: write issued at pointer; pointer and COUNT +1. Pointer = (BASE_ADDR + COUNT) mod 2^ADDR_W, so it wraps silently.
- Rejected accept: no write, pointer/COUNT unchanged, ERR set. ERR_ADDR captured only on the 0→1 transition of ERR. Bundle is consumed (handshake completes).
- CLEAR: next cycle pointer=BASE_ADDR, COUNT=0, FULL=0, ERR=0, ERR_ADDR=0. A write already registered still completes.
- CLEAR and IN_VALID in the same cycle: IN_READY=0, so the bundle is not accepted and the source holds it.

## Timing
- Reset values: WE=0, WADDR=0, WDATA=0, COUNT=0, FULL=0, ERR=0, ERR_ADDR=0, pointer=BASE_ADDR.
- Latency: accept at edge N → WE=1 with WADDR/WDATA valid during cycle N+1, for exactly one cycle per legal word.
- Throughput: one accept per cycle, back-to-back; WE may stay high across consecutive cycles.
- Outputs WE/WADDR/WDATA/COUNT/FULL/ERR/ERR_ADDR are all registered and update together with the write.
  - FULL rises in the same cycle as the WE of the DEPTH-th word.
  - IN_READY drops in that cycle, with no further accept.
- A rejected bundle at edge N: WE=0 in N+1; ERR=1 from N+1.
- RST mid-stream: any pending write is dropped (WE=0 the next cycle); all state returns to reset values.

## Test plan
- I-type: FMT=1, OPCODE=0x13, RD=1, RS1=0, FUNC3=0, IMM=5 → one cycle later WE=1, WADDR=0, WDATA=0x00500093, COUNT=1.
- Back-to-back sequence, one bundle per cycle:
  - S: OPCODE=0x23, FUNC3=2, RS1=3, RS2=2, IMM=8 → 0x0021A423 at addr 0.
  - B: OPCODE=0x63, FUNC3=0, RS1=0, RS2=0, IMM=-4 → 0xFE000EE3 at addr 1.
  - U: OPCODE=0x37, RD=5, IMM=0x12345000 → 0x123452B7 at addr 2.
  - WE high three consecutive cycles; COUNT=3.
- Range errors:
  - I with IMM=2048 at pointer 3 → WE=0, ERR=1, ERR_ADDR=3, COUNT unchanged.
  - Next, B with IMM=6 (legal, even) → written at addr 3.
  - Then J with IMM=3 → rejected; ERR_ADDR stays 3.
- FULL: DEPTH=4, ADDR_W=2, BASE_ADDR=2, IN_VALID held with legal R-types → writes to 2,3,0,1. FULL=1 with the 4th WE; IN_READY=0 afterwards; no 5th write.
- CLEAR while FULL and ERR are set, IN_VALID high in the same cycle → bundle not accepted.
  - Next cycle COUNT=0, FULL=0, ERR=0, IN_READY=1.
  - Held bundle then written at BASE_ADDR.
- RST asserted the cycle after an accept → WE=0 next cycle; all outputs at reset values.

Source files
------------

// File: rtl/core_encode_if.sv
// core_encode_if: field-bundle handshake in, instruction-memory write port and status out.
interface core_encode_if #(parameter int ADDR_W = 12);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    logic [ADDR_W-1:0] err_addr;
    modport master (
        output in_valid, fmt, opcode, func3, func7, rd, rs1, rs2, imm,
        input  in_ready, we, waddr, wdata, count, full, err, err_addr
    );
    modport slave (
        input  in_valid, fmt, opcode, func3, func7, rd, rs1, rs2, imm,
        output in_ready, we, waddr, wdata, count, full, err, err_addr
    );
endinterface

// File: rtl/core_encode.sv
// core_encode: packs decoded RV32 fields into instruction words and writes them to consecutive addresses.
module core_encode #(
    parameter int ADDR_W    = 12,
    parameter int DEPTH     = 4096,
    parameter int BASE_ADDR = 0
) (
    input logic         clk_i,
    input logic         rst_i,
    input logic         clear_i,
    core_encode_if.slave bus
);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] ptr_q, ptr_d, waddr_q, waddr_d, err_addr_q, err_addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, wdata_d, word;
    logic              we_q, we_d, full_q, full_d, err_q, err_d;
    logic              ready, acc, legal;
    logic              fit12, fit13, fit21;
    logic [31:0]       imm;

    assign imm   = bus.imm;
    assign ready = !full_q && !clear_i;
    assign acc   = bus.in_valid && ready;
    // Signed-range checks: upper bits must all repeat the sign bit
    assign fit12 = &imm[31:11] || ~|imm[31:11];
    assign fit13 = &imm[31:12] || ~|imm[31:12];
    assign fit21 = &imm[31:20] || ~|imm[31:20];

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (bus.fmt)
            3'd0: begin
                word  = {bus.func7, bus.rs2, bus.rs1, bus.func3, bus.rd, bus.opcode};
                legal = 1'b1;
            end
            3'd1: begin
                word  = {imm[11:0], bus.rs1, bus.func3, bus.rd, bus.opcode};
                legal = fit12;
            end
            3'd2: begin
                word  = {imm[11:5], bus.rs2, bus.rs1, bus.func3, imm[4:0], bus.opcode};
                legal = fit12;
            end
            3'd3: begin
                word  = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.func3, imm[4:1], imm[11], bus.opcode};
                legal = fit13 && !imm[0];
            end
            3'd4: begin
                word  = {imm[31:12], bus.rd, bus.opcode};
                legal = ~|imm[11:0];
            end
            3'd5: begin
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
                legal = fit21 && !imm[0];
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        ptr_d      = ptr_q;
        count_d    = count_q;
        full_d     = full_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        we_d       = acc && legal;
        waddr_d    = we_d ? ptr_q : waddr_q;
        wdata_d    = we_d ? word : wdata_q;
        if (clear_i) begin
            ptr_d      = BASE;
            count_d    = '0;
            full_d     = 1'b0;
            err_d      = 1'b0;
            err_addr_d = '0;
        end else if (acc && legal) begin
            ptr_d   = ptr_q + ADDR_W'(1);
            count_d = count_q + (ADDR_W+1)'(1);
            full_d  = (count_q + (ADDR_W+1)'(1)) == DEPTH_C;
        end else if (acc) begin
            err_d      = 1'b1;
            err_addr_d = err_q ? err_addr_q : ptr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q      <= BASE;
            count_q    <= '0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.in_ready = ready;
    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign bus.count    = count_q;
    assign bus.full     = full_q;
    assign bus.err      = err_q;
    assign bus.err_addr = err_addr_q;
endmodule
